// File: rtl/operand_arbiter.sv
//==============================================================================
// Module   : operand_arbiter
// Purpose  : Round-robin sharing of one 4-operand compute unit between two
//            requesters. Optional WAIT watchdog via OPARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module operand_arbiter #(
  parameter int data_width     = 16,
  parameter int res_width      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start0,
  input  logic [4*data_width-1:0] ops0,
  output logic                    ready0,
  input  logic                    start1,
  input  logic [4*data_width-1:0] ops1,
  output logic                    ready1,
  output logic                    unitStart,
  output logic [data_width-1:0]   unitA,
  output logic [data_width-1:0]   unitB,
  output logic [data_width-1:0]   unitC,
  output logic [data_width-1:0]   unitD,
  input  logic                    unitReady,
  input  logic                    unitDone,
  input  logic [res_width-1:0]    unitResult,
  output logic [res_width-1:0]    result,
  output logic                    resultValid0,
  output logic                    resultValid1,
  output logic                    grantId,
  output logic                    error
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  logic [1:0]              r_state;
  logic                    r_pend0;
  logic                    r_pend1;
  logic [4*data_width-1:0] r_buf0;
  logic [4*data_width-1:0] r_buf1;
  logic [4*data_width-1:0] r_unit_ops;
  logic [res_width-1:0]    r_result;
  logic                    r_last_grant;
  logic                    r_grant_id;

  logic w_ready0;
  logic w_ready1;
  logic w_pick;
  logic w_timeout;
  logic w_release;
  logic w_clear0;
  logic w_clear1;

  assign w_ready0 = rst_n && !r_pend0;
  assign w_ready1 = rst_n && !r_pend1;

  // On a tie the requester not served last wins; otherwise the only one pending.
  assign w_pick = (r_pend0 && r_pend1) ? ~r_last_grant : r_pend1;

  // A transaction ends either with a normal response or a watchdog abort.
  assign w_release = (r_state == c_st_resp) || w_timeout;
  assign w_clear0  = w_release && (r_grant_id == 1'b0);
  assign w_clear1  = w_release && (r_grant_id == 1'b1);

`ifdef OPARB_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_error;

  assign w_timeout = (r_state == c_st_wait) && !unitDone && (r_wait_cnt == c_timeout_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_error    <= 1'b0;
    end else begin
      r_error <= w_timeout;
      if (r_state == c_st_issue) begin
        r_wait_cnt <= '0;
      end else if (r_state == c_st_wait) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  assign error = r_error;
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= c_st_idle;
      r_pend0      <= 1'b0;
      r_pend1      <= 1'b0;
      r_buf0       <= '0;
      r_buf1       <= '0;
      r_unit_ops   <= '0;
      r_result     <= '0;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
    end else begin
      if (w_clear0) begin
        r_pend0 <= 1'b0;
      end else if (start0 && w_ready0) begin
        r_buf0  <= ops0;
        r_pend0 <= 1'b1;
      end

      if (w_clear1) begin
        r_pend1 <= 1'b0;
      end else if (start1 && w_ready1) begin
        r_buf1  <= ops1;
        r_pend1 <= 1'b1;
      end

      case (r_state)
        c_st_idle: begin
          if (r_pend0 || r_pend1) begin
            r_grant_id <= w_pick;
            r_unit_ops <= w_pick ? r_buf1 : r_buf0;
            r_state    <= c_st_issue;
          end
        end
        c_st_issue: begin
          if (unitReady) begin
            r_state <= c_st_wait;
          end
        end
        c_st_wait: begin
          if (unitDone) begin
            r_result <= unitResult;
            r_state  <= c_st_resp;
          end else if (w_timeout) begin
            r_last_grant <= r_grant_id;
            r_state      <= c_st_idle;
          end
        end
        default: begin
          r_last_grant <= r_grant_id;
          r_state      <= c_st_idle;
        end
      endcase
    end
  end

  assign ready0       = w_ready0;
  assign ready1       = w_ready1;
  assign unitStart    = rst_n && (r_state == c_st_issue) && unitReady;
  assign resultValid0 = rst_n && (r_state == c_st_resp) && (r_grant_id == 1'b0);
  assign resultValid1 = rst_n && (r_state == c_st_resp) && (r_grant_id == 1'b1);
  assign unitA        = r_unit_ops[data_width-1:0];
  assign unitB        = r_unit_ops[2*data_width-1:data_width];
  assign unitC        = r_unit_ops[3*data_width-1:2*data_width];
  assign unitD        = r_unit_ops[4*data_width-1:3*data_width];
  assign result       = r_result;
  assign grantId      = r_grant_id;

endmodule

`default_nettype wire

// File: doc/operand_arbiter.md
Name: operand_arbiter

Overview:
- Shares one 4-operand compute unit between two operand-collecting front ends (requesters 0 and 1).
- Latches each requester's operand set, grants the unit round-robin and sequences the unit's start/done handshake.
- Returns the result to the granted requester with a one-cycle valid pulse.
- Sits between the input-collection stage and the shared arithmetic datapath.

Parameters:
- data_width, 16, width of each operand word.
- res_width, 32, width of the unit result.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles. Used only with OPARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start0  in  1  requester 0 operand set valid; sampled only while ready0=1.
- ops0  in  4*data_width  requester 0 operands, packed {d,c,b,a}, a in the LSBs.
- ready0  out  1  arbiter can accept a request from requester 0.
- start1  in  1  requester 1 operand set valid.
- ops1  in  4*data_width  requester 1 operands, same packing as ops0.
- ready1  out  1  arbiter can accept a request from requester 1.
- unitStart  out  1  one-cycle start pulse to the compute unit.
- unitA, unitB, unitC, unitD  out  data_width each  operands to the unit.
- unitReady  in  1  compute unit idle.
- unitDone  in  1  compute unit result valid (pulse).
- unitResult  in  res_width  compute unit result.
- result  out  res_width  last captured result.
- resultValid0, resultValid1  out  1  one-cycle result pulse per requester.
- grantId  out  1  requester currently or last served.
- error  out  1  timeout pulse; held 0 without OPARB_TIMEOUT_EN.

Behaviour:
- Accept: start_i && ready_i at edge T → operands copied into buffer_i and pend_i set at T+1. readyi = !pend_i. start_i while ready_i=0 is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any pend is set, choose a requester round-robin and go to ISSUE.
  - Both pending: grant the requester other than lastGrant.
  - lastGrant resets to 1, so requester 0 wins the first tie.
  - grantId and unitA..D are loaded from the chosen buffer on the transition.
- ISSUE: unitStart = unitReady (combinational from state). When unitReady=1, go to WAIT next cycle. Otherwise hold, with unitA..D stable.
- WAIT: on unitDone=1, capture unitResult into result and go to RESP.
- RESP, one cycle:
  - resultValid_grantId = 1.
  - pend_grantId cleared at the end of the cycle, so ready rises on the following cycle.
  - lastGrant = grantId; return to IDLE.
- unitDone in IDLE, ISSUE or RESP is ignored.
- Latency from an accepted start with an idle unit and no contention:
  - unitStart at T+2.
  - resultValid one cycle after the unitDone edge.
- Simultaneous start0 and start1 in the same cycle: both are accepted. They are served back-to-back in round-robin order.
- A new start from the non-granted requester during ISSUE, WAIT or RESP is accepted if its ready is high.
- The buffer of the granted requester is not overwritten while it is pending.
- result holds its value until the next capture. resultValid0 and resultValid1 are never high together.
- Reset (rst_n=0 at an edge), at any time including mid-operation:
  - state=IDLE; pend0 and pend1 cleared; buffers, result, unitA..D and grantId = 0; lastGrant = 1; error = 0.
  - Combinational outputs while rst_n=0: unitStart=0, resultValid*=0, ready0=ready1=0.
  - After release: ready0=ready1=1.

Optional Feature:
- OPARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and counts each cycle in WAIT.
  - If it reaches TIMEOUT_CYCLES without unitDone, then:
    - error pulses for one cycle;
    - pend_grantId is cleared and result is unchanged;
    - no resultValid is issued;
    - lastGrant is updated and the FSM returns to IDLE.
- OPARB_TIMEOUT_EN undefined: no counter; WAIT has no bound; error is tied to 0.

Test Plan:
- Single request: ops0={4,3,2,1}, start0 for one cycle, unit returns done 3 cycles after unitStart with 0x0000000A.
  → unitA..D=1,2,3,4; exactly one unitStart; resultValid0 for one cycle; result=0xA; ready0 back to 1.
- Tie: start0 and start1 on the same cycle after reset.
  → requester 0 served first, then requester 1; grantId 0 then 1; two separate unitStart pulses.
- Fairness: requester 0 re-requests immediately after each resultValid0 while requester 1 stays pending.
  → grants strictly alternate 0,1,0,1.
- Back-pressure: unitReady=0 for 5 cycles in ISSUE.
  → unitStart stays 0; operands stay stable; a single unitStart in the cycle unitReady rises.
- Spurious inputs: unitDone pulsed in IDLE, and start1 while ready1=0.
  → no state change, no resultValid, buffer1 unchanged.
- Reset in WAIT: rst_n low for one cycle.
  → pends cleared; no resultValid; a later unitDone is ignored. With OPARB_TIMEOUT_EN and TIMEOUT_CYCLES=8 and no unitDone: error pulses 8 cycles after WAIT entry and ready0 returns to 1.
